dmem_access_ctrl: RTL

Data-memory access controller between the MEM pipeline stage and the single-port D-memory SRAM. It arbitrates the SRAM between two requesters: the core load/store path (MEM stage) and an auxiliary word port (interrupt context save/restore unit). It generates SRAM strobes, byte write enables and replicated write data, and returns sign/zero-extended load data one cycle after grant. Misaligned and illegal core accesses are trapped and never reach the SRAM.

---
 rtl/dmem_access_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: arbitrates the single-port D-SRAM between the
// core load/store path and the aux word port, formats stores and loads, traps bad core accesses.
module dmem_access_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [31:0]       core_addr_i,
  input  logic [31:0]       core_wdata_i,
  input  logic [2:0]        core_type_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [31:0]       core_rdata_o,
  output logic              core_err_o,
  input  logic              aux_req_i,
  input  logic              aux_we_i,
  input  logic [31:0]       aux_addr_i,
  input  logic [31:0]       aux_wdata_i,
  output logic              aux_gnt_o,
  output logic              aux_rvalid_o,
  output logic [31:0]       aux_rdata_o,
  output logic              sram_cen_o,
  output logic              sram_wen_o,
  output logic [3:0]        sram_bwen_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  input  logic [31:0]       sram_rdata_i
);

  localparam logic [2:0] T_B  = 3'b000;
  localparam logic [2:0] T_H  = 3'b001;
  localparam logic [2:0] T_W  = 3'b010;
  localparam logic [2:0] T_BU = 3'b100;
  localparam logic [2:0] T_HU = 3'b101;
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  // Extract and extend the addressed byte/half of a raw SRAM word.
  function automatic logic [31:0] load_format(input logic [2:0] typ, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (typ)
      T_B:     r = {{24{b[7]}}, b};
      T_BU:    r = {24'h000000, b};
      T_H:     r = {{16{h[15]}}, h};
      T_HU:    r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  logic [3:0] starve_r;
  logic       aux_gnt_s;
  logic       core_gnt_s;
  logic       core_bad_s;
  logic       rsp_valid_r;
  logic       rsp_port_r;
  logic       rsp_load_r;
  logic [2:0] rsp_type_r;
  logic [1:0] rsp_off_r;
  logic       rsp_err_r;
  logic       unused_s;

  assign unused_s = ^{core_addr_i[31:ADDR_W+2], aux_addr_i[31:ADDR_W+2], aux_addr_i[1:0]};

  // Core access legality: alignment per size, reserved type encodings.
  always_comb begin
    core_bad_s = 1'b0;
    case (core_type_i)
      T_B, T_BU: core_bad_s = 1'b0;
      T_H, T_HU: core_bad_s = core_addr_i[0];
      T_W:       core_bad_s = (core_addr_i[1:0] != 2'b00);
      default:   core_bad_s = 1'b1;
    endcase
  end

  // Arbitration: core first unless aux has waited MAX_WAIT cycles.
  always_comb begin
    aux_gnt_s  = 1'b0;
    core_gnt_s = 1'b0;
    if (resetn && aux_req_i && ((starve_r == WAIT_MAX) || !core_req_i)) begin
      aux_gnt_s = 1'b1;
    end else if (resetn && core_req_i) begin
      core_gnt_s = 1'b1;
    end else begin
      aux_gnt_s  = 1'b0;
      core_gnt_s = 1'b0;
    end
  end

  assign core_gnt_o = core_gnt_s;
  assign aux_gnt_o  = aux_gnt_s;

  // SRAM strobes and store formatting for the granted access; trapped core accesses stay idle.
  always_comb begin
    sram_cen_o   = 1'b1;
    sram_wen_o   = 1'b1;
    sram_bwen_o  = 4'b1111;
    sram_addr_o  = {ADDR_W{1'b0}};
    sram_wdata_o = 32'h0000_0000;
    if (aux_gnt_s) begin
      sram_cen_o   = 1'b0;
      sram_wen_o   = ~aux_we_i;
      sram_bwen_o  = aux_we_i ? 4'b0000 : 4'b1111;
      sram_addr_o  = aux_addr_i[ADDR_W+1:2];
      sram_wdata_o = aux_we_i ? aux_wdata_i : 32'h0000_0000;
    end else if (core_gnt_s && !core_bad_s) begin
      sram_cen_o  = 1'b0;
      sram_wen_o  = ~core_we_i;
      sram_addr_o = core_addr_i[ADDR_W+1:2];
      if (core_we_i) begin
        case (core_type_i[1:0])
          2'b00: begin
            sram_wdata_o = {4{core_wdata_i[7:0]}};
            sram_bwen_o  = ~(4'b0001 << core_addr_i[1:0]);
          end
          2'b01: begin
            sram_wdata_o = {2{core_wdata_i[15:0]}};
            sram_bwen_o  = ~(4'b0011 << core_addr_i[1:0]);
          end
          default: begin
            sram_wdata_o = core_wdata_i;
            sram_bwen_o  = 4'b0000;
          end
        endcase
      end else begin
        sram_wdata_o = 32'h0000_0000;
        sram_bwen_o  = 4'b1111;
      end
    end else begin
      sram_cen_o   = 1'b1;
      sram_wen_o   = 1'b1;
      sram_bwen_o  = 4'b1111;
      sram_addr_o  = {ADDR_W{1'b0}};
      sram_wdata_o = 32'h0000_0000;
    end
  end

  // Aux starvation counter, saturating at MAX_WAIT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_r <= 4'd0;
    end else if (!aux_req_i || aux_gnt_s) begin
      starve_r <= 4'd0;
    end else if (starve_r != WAIT_MAX) begin
      starve_r <= starve_r + 4'd1;
    end else begin
      starve_r <= starve_r;
    end
  end

  // Response register: remembers who was granted and how to format the returning word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_valid_r <= 1'b0;
      rsp_port_r  <= 1'b0;
      rsp_load_r  <= 1'b0;
      rsp_type_r  <= 3'b000;
      rsp_off_r   <= 2'b00;
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= aux_gnt_s | core_gnt_s;
      rsp_port_r  <= aux_gnt_s;
      rsp_load_r  <= aux_gnt_s ? ~aux_we_i : ~core_we_i;
      rsp_type_r  <= aux_gnt_s ? T_W : core_type_i;
      rsp_off_r   <= aux_gnt_s ? 2'b00 : core_addr_i[1:0];
      rsp_err_r   <= core_gnt_s & core_bad_s;
    end
  end

  assign core_rvalid_o = rsp_valid_r & ~rsp_port_r & rsp_load_r & ~rsp_err_r;
  assign core_err_o    = rsp_valid_r & ~rsp_port_r & rsp_err_r;
  assign aux_rvalid_o  = rsp_valid_r & rsp_port_r & rsp_load_r;
  assign core_rdata_o  = core_rvalid_o ? load_format(rsp_type_r, rsp_off_r, sram_rdata_i) : 32'h0000_0000;
  assign aux_rdata_o   = aux_rvalid_o ? sram_rdata_i : 32'h0000_0000;

endmodule
